// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 16x oversample tick generator plus a byte FIFO
// with valid/ready pop, occupancy threshold interrupt and sticky overflow flag.
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4,
  parameter int DIV_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rx_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_clken,
  input  logic [7:0]       i_rx_dout_8b,
  input  logic             i_rx_dout_valid,
  output logic [7:0]       o_rd_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  input  logic             i_flush,
  input  logic [CNT_W-1:0] i_thresh,
  output logic [CNT_W-1:0] o_count,
  output logic             o_irq,
  output logic             o_overflow,
  input  logic             i_clr_overflow
);

  localparam int               PTR_W    = CNT_W - 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_last;

  // Divisors 0 and 1 both collapse to a terminal count of 0 (tick every cycle).
  assign div_last = (i_div <= DIV_W'(1)) ? '0 : i_div - DIV_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt     <= '0;
      o_clken <= 1'b0;
    end else if (!i_rx_en) begin
      cnt     <= '0;
      o_clken <= 1'b0;
    end else if (cnt >= div_last) begin
      cnt     <= '0;
      o_clken <= 1'b1;
    end else begin
      cnt     <= cnt + DIV_W'(1);
      o_clken <= 1'b0;
    end
  end

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             push_req;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  // A flush swallows any push or pop in the same cycle, so neither moves
  // pointers nor counts as a dropped byte.
  always_comb begin
    push_req = i_rx_dout_valid && i_rx_en;
    full     = (count == FULL_CNT);
    pop      = (count != '0) && i_rd_ready && !i_flush;
    push     = push_req && (!full || pop) && !i_flush;
    drop     = push_req && full && !pop && !i_flush;
  end

  always_comb begin
    count_nxt = count;
    if (i_flush) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (push) begin
      mem[wr_ptr] <= i_rx_dout_8b;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // The irq looks at next-state count so it lines up with o_count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count      <= '0;
      o_irq      <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      count <= count_nxt;
      o_irq <= (i_thresh != '0) && (count_nxt >= i_thresh);
      if (drop) begin
        o_overflow <= 1'b1;
      end else if (i_clr_overflow) begin
        o_overflow <= 1'b0;
      end
    end
  end

  assign o_count    = count;
  assign o_rd_valid = (count != '0);
  assign o_rd_data  = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_rx_ctrl;

  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 4;
  localparam int DIV_W      = 16;

  logic             clk;
  logic             rst;
  logic             rx_en;
  logic [DIV_W-1:0] div;
  logic             clken;
  logic [7:0]       rx_dout_8b;
  logic             rx_dout_valid;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             flush;
  logic [CNT_W-1:0] thresh;
  logic [CNT_W-1:0] count;
  logic             irq;
  logic             overflow;
  logic             clr_overflow;

  int tests = 0;
  int fails = 0;

  uart_rx_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_en(rx_en), .i_div(div), .o_clken(clken),
    .i_rx_dout_8b(rx_dout_8b), .i_rx_dout_valid(rx_dout_valid),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
    .i_flush(flush), .i_thresh(thresh), .o_count(count), .o_irq(irq),
    .o_overflow(overflow), .i_clr_overflow(clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    rx_dout_valid = v;
    rx_dout_8b    = d;
    rd_ready      = r;
    step();
  endtask

  // Reference model: the FIFO is a plain queue; ticks come from counting
  // enabled cycles since the last tick against the effective divisor.
  byte unsigned exp_q[$];
  logic exp_clken = 1'b0;
  logic exp_ovf   = 1'b0;
  logic exp_irq   = 1'b0;
  logic last_rst  = 1'b0;
  logic started   = 1'b0;
  int   elapsed   = 0;

  always @(posedge clk) begin
    int  eff;
    logic pop_ok, push_req, was_full, dropped;
    if (rst) begin
      exp_q.delete();
      exp_ovf   = 1'b0;
      exp_irq   = 1'b0;
      exp_clken = 1'b0;
      elapsed   = 0;
      last_rst  = 1'b1;
    end else begin
      last_rst = 1'b0;
      if (!rx_en) begin
        elapsed   = 0;
        exp_clken = 1'b0;
      end else begin
        eff = (int'(div) <= 1) ? 1 : int'(div);
        if (elapsed + 1 >= eff) begin
          elapsed   = 0;
          exp_clken = 1'b1;
        end else begin
          elapsed++;
          exp_clken = 1'b0;
        end
      end
      dropped = 1'b0;
      if (flush) begin
        exp_q.delete();
      end else begin
        pop_ok   = (exp_q.size() != 0) && rd_ready;
        push_req = rx_dout_valid && rx_en;
        was_full = (exp_q.size() == FIFO_DEPTH);
        if (pop_ok) void'(exp_q.pop_front());
        if (push_req) begin
          if (!was_full || pop_ok) exp_q.push_back(rx_dout_8b);
          else dropped = 1'b1;
        end
      end
      if (dropped) exp_ovf = 1'b1;
      else if (clr_overflow) exp_ovf = 1'b0;
      exp_irq = (thresh != 0) && (exp_q.size() >= int'(thresh));
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      checkOutput("clken", 32'(clken), 32'(exp_clken));
      checkOutput("count", 32'(count), 32'(exp_q.size()));
      checkOutput("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
      checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
      checkOutput("irq", 32'(irq), 32'(exp_irq));
      if (exp_q.size() != 0) checkOutput("rd_data", 32'(rd_data), 32'(exp_q[0]));
      else if (last_rst) checkOutput("rd_data_rst", 32'(rd_data), 32'h00);
    end
  end

  initial begin
    int first, pulses;
    byte unsigned order[3];
    rst = 1'b1; rx_en = 1'b0; div = 16'd5; rx_dout_8b = 8'h00; rx_dout_valid = 1'b0;
    rd_ready = 1'b0; flush = 1'b0; thresh = '0; clr_overflow = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset_data", 32'(rd_data), 32'h00);
    checkOutput("reset_ovf", 32'(overflow), 32'd0);

    rx_en = 1'b1; first = -1; pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (clken) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    checkOutput("tick_first_div5", 32'(first), 32'd5);
    checkOutput("tick_count_div5", 32'(pulses), 32'd8);
    div = 16'd1; pulses = 0;
    for (int i = 0; i < 10; i++) begin step(); if (clken) pulses++; end
    checkOutput("tick_count_div1", 32'(pulses), 32'd10);
    rx_en = 1'b0; step(); pulses = 0;
    for (int i = 0; i < 10; i++) begin step(); if (clken) pulses++; end
    checkOutput("tick_count_off", 32'(pulses), 32'd0);
    rx_en = 1'b1; div = 16'd5;

    order[0] = 8'h11; order[1] = 8'h22; order[2] = 8'h33;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, order[i], 1'b0);
    rx_dout_valid = 1'b0;
    checkOutput("order_count3", 32'(count), 32'd3);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("order_data", 32'(rd_data), 32'(order[i]));
      step();
      checkOutput("order_count", 32'(count), 32'(2 - i));
    end
    checkOutput("order_empty", 32'(rd_valid), 32'd0);
    rd_ready = 1'b0;

    for (int i = 0; i <= 8; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    rx_dout_valid = 1'b0;
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    checkOutput("ovf_count", 32'(count), 32'd8);
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput("ovf_drain", 32'(rd_data), 32'(i));
      step();
    end
    rd_ready = 1'b0;
    clr_overflow = 1'b1; step(); clr_overflow = 1'b0;
    checkOutput("ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
    applyStimulus(1'b1, 8'h98, 1'b0);
    clr_overflow = 1'b1;
    applyStimulus(1'b1, 8'h99, 1'b0);
    checkOutput("ovf_clr_vs_set", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    clr_overflow = 1'b0;
    checkOutput("ovf_clr2", 32'(overflow), 32'd0);

    applyStimulus(1'b1, 8'hAA, 1'b1);
    checkOutput("full_pp_ovf", 32'(overflow), 32'd0);
    checkOutput("full_pp_count", 32'(count), 32'd8);
    rx_dout_valid = 1'b0; rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput("full_pp_drain", 32'(rd_data), (i == 7) ? 32'hAA : 32'(8'h41 + i));
      step();
    end
    rd_ready = 1'b0;

    thresh = 4'd3;
    applyStimulus(1'b1, 8'h01, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0);
    checkOutput("irq_below", 32'(irq), 32'd0);
    applyStimulus(1'b1, 8'h03, 1'b0);
    checkOutput("irq_at", 32'(irq), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("irq_after_pop", 32'(irq), 32'd0);
    thresh = 4'd0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h51 + i), 1'b0);
    checkOutput("irq_disabled", 32'(irq), 32'd0);
    checkOutput("pre_flush_count", 32'(count), 32'd5);

    flush = 1'b1;
    applyStimulus(1'b1, 8'h77, 1'b0);
    flush = 1'b0;
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_valid", 32'(rd_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("flush_lost", 32'(count), 32'd0);

    thresh = 4'd3;
    for (int i = 0; i <= 8; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
    checkOutput("pre_rst_ovf", 32'(overflow), 32'd1);
    rst = 1'b1;
    applyStimulus(1'b1, 8'hEE, 1'b0);
    rst = 1'b0;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_data", 32'(rd_data), 32'h00);
    checkOutput("rst_clken", 32'(clken), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      rx_en         = ($urandom_range(0, 19) != 0);
      rx_dout_valid = ($urandom_range(0, 1) == 1);
      rx_dout_8b    = 8'($urandom);
      rd_ready      = ($urandom_range(0, 9) < ((i < 1500) ? 3 : 6));
      flush         = ($urandom_range(0, 59) == 0);
      clr_overflow  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) div = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) thresh = 4'($urandom_range(0, 8));
      step();
    end
    rst = 1'b0; rx_dout_valid = 1'b0; flush = 1'b0; clr_overflow = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
